// File: rtl/sdram_frame_port.sv
// Streams a circular frame buffer from SDRAM ch1 into a read FIFO and interleaves plotter writes.
// One transaction at a time; fixed read latency and write gap, since the controller has no handshake.
module sdram_frame_port #(
  parameter logic [23:0] FRAME_BASE     = 24'h000000,
  parameter int          FRAME_WORDS    = 16384,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          LOW_WATER      = 4,
  parameter int          READ_LATENCY   = 9,
  parameter int          WRITE_GAP      = 4,
  parameter int          STARTUP_CYCLES = 12160
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          frame_start,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [23:0]                   wr_addr,
  input  logic [15:0]                   wr_data,
  output logic [31:0]                   rd_data,
  output logic                          rd_valid,
  input  logic                          rd_pop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [23:0]                   ch1_addr,
  output logic [15:0]                   ch1_din,
  output logic                          ch1_req,
  output logic                          ch1_rnw,
  input  logic [31:0]                   ch1_dout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int CW = $clog2(STARTUP_CYCLES + READ_LATENCY + WRITE_GAP + 1);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RD,
    ST_WAIT_WR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [23:0]     pend_addr_q, pend_addr_d;
  logic [15:0]     pend_data_q, pend_data_d;
  logic            discard_q, discard_d;
  logic            req_q, req_d;
  logic            rnw_q, rnw_d;
  logic [23:0]     addr_q, addr_d;
  logic [15:0]     din_q, din_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [31:0]     mem_d [FIFO_DEPTH];

  logic            fifo_full;
  logic            sel_wr;
  logic            wr_acc;
  logic            push;
  logic            pop;
  logic [IW:0]     idx_inc;
  logic [IW-1:0]   idx_next;
  logic [23:0]     rd_addr;

  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign sel_wr     = pend_q && ((level_q >= LW'(LOW_WATER)) || fifo_full);
  assign wr_ready   = !pend_q && (state_q != ST_STARTUP);
  assign wr_acc     = wr_valid && wr_ready;
  assign pop        = rd_pop && (level_q != '0) && !frame_start;
  assign idx_inc    = {1'b0, idx_q} + (IW+1)'(1);
  assign idx_next   = (idx_inc == (IW+1)'(FRAME_WORDS)) ? '0 : idx_inc[IW-1:0];
  assign rd_addr    = FRAME_BASE + {{(23-IW){1'b0}}, idx_q, 1'b0};

  assign ch1_req    = req_q;
  assign ch1_rnw    = rnw_q;
  assign ch1_addr   = addr_q;
  assign ch1_din    = din_q;
  assign rd_data    = mem_q[rd_ptr_q];
  assign rd_valid   = (level_q != '0);
  assign fifo_level = level_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    discard_d   = discard_q;
    req_d       = 1'b0;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    din_d       = din_q;
    push        = 1'b0;

    case (state_q)
      ST_STARTUP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STARTUP_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        discard_d = 1'b0;
        // A restart cycle issues nothing so the next read starts cleanly at index 0.
        if (!frame_start) begin
          if (sel_wr || (fifo_full && pend_q)) begin
            req_d   = 1'b1;
            rnw_d   = 1'b0;
            addr_d  = pend_addr_q;
            din_d   = pend_data_q;
            pend_d  = 1'b0;
            state_d = ST_REQ;
          end else if (!fifo_full) begin
            req_d   = 1'b1;
            rnw_d   = 1'b1;
            addr_d  = rd_addr;
            idx_d   = idx_next;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d   = CW'(1);
        state_d = rnw_q ? ST_WAIT_RD : ST_WAIT_WR;
        if (frame_start && rnw_q) discard_d = 1'b1;
      end
      ST_WAIT_RD: begin
        cnt_d = cnt_q + CW'(1);
        if (frame_start) discard_d = 1'b1;
        if (cnt_q == CW'(READ_LATENCY - 1)) begin
          push    = !discard_q && !frame_start;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_WAIT_WR: begin
        cnt_d = cnt_q + CW'(1);
        // Leave one cycle early: the IDLE decision cycle completes the gap.
        if (cnt_q >= CW'(WRITE_GAP - 2)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    if (wr_acc) begin
      pend_d      = 1'b1;
      pend_addr_d = wr_addr;
      pend_data_d = wr_data;
    end
    if (frame_start) idx_d = '0;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (frame_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = ch1_dout;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_STARTUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      discard_q   <= 1'b0;
      req_q       <= 1'b0;
      rnw_q       <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      discard_q   <= discard_d;
      req_q       <= req_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
